// File: rtl/ts_pkg.sv
// Shared constants and types for the MPEG transport-stream packet sender:
// register map, control bits, packet geometry and FSM encodings.
package ts_pkg;

  localparam int ADDR_CTRL      = 0;
  localparam int ADDR_GAP       = 1;
  localparam int ADDR_PKT_COUNT = 2;
  localparam int ADDR_STATUS    = 3;
  localparam int ADDR_BUF_BASE  = 128;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_BYTES = 188;
  localparam int         TS_PKT_WORDS = 47;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef struct packed {
    logic [15:0] sent;
    logic [11:0] rsvd;
    logic        wr_err;
    logic        sync_err;
    logic        done;
    logic        busy;
  } ts_status_t;

  // Buffer words are little-endian: lane 0 is the lowest-addressed byte.
  function automatic logic [7:0] ts_byte_sel(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_pkt_sender_if.sv
// Register bus plus MPEG byte stream of the TS packet sender, bundled so the
// sender and its bus owner see one connection.
interface ts_pkt_sender_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10
);

  logic                              wen;
  logic [OPT_MEM_ADDR_BITS:0]        waddr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                              ren;
  logic [OPT_MEM_ADDR_BITS:0]        raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
  logic [7:0]                        mpeg_data;
  logic                              mpeg_valid;
  logic                              mpeg_sync;

  modport master (
    output wen, waddr, wdata, wstrb, ren, raddr,
    input  rdata, mpeg_data, mpeg_valid, mpeg_sync
  );

  modport slave (
    input  wen, waddr, wdata, wstrb, ren, raddr,
    output rdata, mpeg_data, mpeg_valid, mpeg_sync
  );

endinterface

// File: rtl/ts_pkt_buf.sv
// One-packet buffer: 47 little-endian words with a byte-enabled write port,
// a word read port for the register bus and a byte fetch port for the sender.
module ts_pkt_buf
  import ts_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [5:0]  raddr,
  output logic [31:0] rdata,
  input  logic [7:0]  fetch_idx,
  output logic [7:0]  fetch_byte
);

  logic [31:0] mem [TS_PKT_WORDS];
  logic [31:0] fetch_word;

  // Contents survive reset so a packet can be replayed after recovery.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < TS_PKT_WORDS)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < TS_PKT_WORDS) begin
      rdata = mem[raddr];
    end
    fetch_word = mem[fetch_idx[7:2]];
    fetch_byte = ts_byte_sel(fetch_word, fetch_idx[1:0]);
  end

endmodule

// File: rtl/ts_pkt_sender.sv
// Replays a buffered 188-byte TS packet as a paced byte stream, with a small
// register map for pacing, packet count, start/abort and status.
module ts_pkt_sender
  import ts_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10,
  parameter int DEFAULT_GAP        = 3
) (
  input  logic               clk,
  input  logic               rst,
  ts_pkt_sender_if.slave     bus
);

  localparam int AW = OPT_MEM_ADDR_BITS + 1;
  localparam logic [AW-1:0] A_CTRL      = AW'(ADDR_CTRL);
  localparam logic [AW-1:0] A_GAP       = AW'(ADDR_GAP);
  localparam logic [AW-1:0] A_PKT_COUNT = AW'(ADDR_PKT_COUNT);
  localparam logic [AW-1:0] A_STATUS    = AW'(ADDR_STATUS);
  localparam logic [AW-1:0] A_BUF_LO    = AW'(ADDR_BUF_BASE);
  localparam logic [AW-1:0] A_BUF_HI    = AW'(ADDR_BUF_BASE + TS_PKT_WORDS - 1);
  localparam logic [7:0]    LAST_IDX    = 8'(TS_PKT_BYTES - 1);

  logic [1:0]  state;
  logic [7:0]  idx;
  logic [7:0]  idx_succ;
  logic [7:0]  fetch_idx;
  logic [7:0]  fetch_byte;
  logic [7:0]  gap_reg;
  logic [7:0]  gap_run;
  logic [7:0]  gap_cnt;
  logic [15:0] pkt_count_reg;
  logic [15:0] pkt_count_run;
  logic [15:0] sent;
  logic [15:0] sent_inc;
  logic        done;
  logic        sync_err;
  logic        wr_err;
  logic        busy;
  logic        ctrl_wr;
  logic        start_req;
  logic        abort_req;
  logic        cfg_wr;
  logic        buf_wr_hit;
  logic        buf_rd_hit;
  logic        more_pkts;
  logic [5:0]  buf_waddr;
  logic [5:0]  buf_raddr;
  logic [31:0] buf_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        sync_q;
  ts_status_t  status;

  ts_pkt_buf u_buf (
    .clk        (clk),
    .we         (buf_wr_hit && !busy),
    .waddr      (buf_waddr),
    .wdata      (bus.wdata),
    .wstrb      (bus.wstrb),
    .raddr      (buf_raddr),
    .rdata      (buf_rdata),
    .fetch_idx  (fetch_idx),
    .fetch_byte (fetch_byte)
  );

  // The fetch address always points at the byte that will be registered next.
  always_comb begin
    busy       = (state != ST_IDLE);
    ctrl_wr    = bus.wen && (bus.waddr == A_CTRL);
    abort_req  = ctrl_wr && bus.wdata[CTRL_ABORT_BIT];
    start_req  = ctrl_wr && bus.wdata[CTRL_START_BIT] && !bus.wdata[CTRL_ABORT_BIT];
    cfg_wr     = bus.wen && ((bus.waddr == A_GAP) || (bus.waddr == A_PKT_COUNT));
    buf_wr_hit = bus.wen && (bus.waddr >= A_BUF_LO) && (bus.waddr <= A_BUF_HI);
    buf_rd_hit = (bus.raddr >= A_BUF_LO) && (bus.raddr <= A_BUF_HI);
    buf_waddr  = 6'(bus.waddr - A_BUF_LO);
    buf_raddr  = 6'(bus.raddr - A_BUF_LO);
    idx_succ   = (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    sent_inc   = (sent == 16'hFFFF) ? sent : sent + 16'd1;
    more_pkts  = (pkt_count_run == 16'd0) || (sent_inc < pkt_count_run);
    case (state)
      ST_SEND: fetch_idx = idx_succ;
      ST_GAP:  fetch_idx = idx;
      default: fetch_idx = 8'd0;
    endcase
    status          = '0;
    status.busy     = busy;
    status.done     = done;
    status.sync_err = sync_err;
    status.wr_err   = wr_err;
    status.sent     = sent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_reg       <= 8'(DEFAULT_GAP);
      pkt_count_reg <= '0;
    end else if (cfg_wr && !busy) begin
      if (bus.waddr == A_GAP) begin
        gap_reg <= bus.wdata[7:0];
      end else begin
        pkt_count_reg <= bus.wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (bus.ren) begin
      if (buf_rd_hit) begin
        rdata_q <= buf_rdata;
      end else if (bus.raddr == A_GAP) begin
        rdata_q <= {24'd0, gap_reg};
      end else if (bus.raddr == A_PKT_COUNT) begin
        rdata_q <= {16'd0, pkt_count_reg};
      end else if (bus.raddr == A_STATUS) begin
        rdata_q <= status;
      end else begin
        rdata_q <= '0;
      end
    end
  end

  // Outputs are loaded on the edge that enters a SEND cycle, so valid lines
  // up with the SEND state rather than trailing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      gap_run       <= '0;
      gap_cnt       <= '0;
      pkt_count_run <= '0;
      sent          <= '0;
      done          <= 1'b0;
      sync_err      <= 1'b0;
      wr_err        <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sync_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      if (abort_req && busy) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_req) begin
              state         <= ST_CHECK;
              gap_run       <= gap_reg;
              pkt_count_run <= pkt_count_reg;
              sent          <= '0;
              done          <= 1'b0;
              sync_err      <= 1'b0;
              wr_err        <= 1'b0;
            end
          end
          ST_CHECK: begin
            if (fetch_byte != TS_SYNC_BYTE) begin
              sync_err <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state   <= ST_SEND;
              idx     <= 8'd0;
              valid_q <= 1'b1;
              sync_q  <= 1'b1;
              data_q  <= fetch_byte;
            end
          end
          ST_SEND: begin
            if (idx == LAST_IDX) begin
              sent <= sent_inc;
              if (!more_pkts) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end
            if ((idx != LAST_IDX) || more_pkts) begin
              idx <= idx_succ;
              if (gap_run == 8'd0) begin
                valid_q <= 1'b1;
                sync_q  <= (idx_succ == 8'd0);
                data_q  <= fetch_byte;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= gap_run;
              end
            end
          end
          default: begin
            if (gap_cnt == 8'd1) begin
              state   <= ST_SEND;
              valid_q <= 1'b1;
              sync_q  <= (idx == 8'd0);
              data_q  <= fetch_byte;
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
        endcase
      end
      if (busy && (cfg_wr || buf_wr_hit)) begin
        wr_err <= 1'b1;
      end
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.mpeg_data  = data_q;
  assign bus.mpeg_valid = valid_q;
  assign bus.mpeg_sync  = sync_q;

endmodule

// File: tb/tb_ts_pkt_sender.sv
// Self-checking bench for ts_pkt_sender: register-map vector table plus
// scoreboarded packet runs covering pacing, multi-packet, sync error, abort and reset.
module tb_ts_pkt_sender;

  typedef struct packed {
    logic       sync;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0] pkt [188];
  sb_t  exp_q [$];
  vec_t vecs [$];

  ts_pkt_sender_if #(.C_S_AXI_DATA_WIDTH(32), .OPT_MEM_ADDR_BITS(10)) bus ();

  ts_pkt_sender #(
    .C_S_AXI_DATA_WIDTH (32),
    .OPT_MEM_ADDR_BITS  (10),
    .DEFAULT_GAP        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reg_write(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    bus.wen   = 1'b1;
    bus.waddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    @(negedge clk);
    bus.wen   = 1'b0;
  endtask

  task automatic reg_read(input logic [10:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.ren   = 1'b1;
    bus.raddr = addr;
    @(negedge clk);
    bus.ren   = 1'b0;
    data      = bus.rdata;
  endtask

  function automatic vec_t mkv(input logic wr, input logic [10:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    if (v.wr) reg_write(v.addr, v.wdata, v.strb);
  endtask

  task automatic check_output(input vec_t v);
    logic [31:0] rd;
    reg_read(v.addr, rd);
    check_val(v.name, rd, v.exp);
  endtask

  function automatic logic [31:0] word_of(input int w);
    return {pkt[4*w+3], pkt[4*w+2], pkt[4*w+1], pkt[4*w]};
  endfunction

  task automatic load_packet();
    for (int w = 0; w < 47; w++) reg_write(11'(128 + w), word_of(w), 4'hF);
  endtask

  task automatic push_packets(input int n);
    sb_t e;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 188; i++) begin
        e.sync = (i == 0);
        e.data = pkt[i];
        exp_q.push_back(e);
      end
    end
  endtask

  // Issues a CTRL write, then follows the stream cycle by cycle; action 1 aborts
  // and action 2 resets right after byte stop_at has been observed.
  task automatic watch(input logic [31:0] ctrl, input int gap, input int poke_at, input int stop_at,
                       input int action, input int limit, input string tag, output int n_seen);
    int  cyc, last_cyc, spacing_err;
    bit  seen_first, fin;
    sb_t e;
    cyc = 0; last_cyc = 0; spacing_err = 0; seen_first = 0; fin = 0; n_seen = 0;
    @(negedge clk);
    bus.wen = 1'b1; bus.waddr = 11'd0; bus.wdata = ctrl; bus.wstrb = 4'hF;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.wen = 1'b0;
      if (bus.mpeg_valid) begin
        n_seen++;
        if (!seen_first) begin
          seen_first = 1;
          check_val({tag, " first latency"}, cyc, 2);
        end else if (cyc - last_cyc != gap + 1) begin
          spacing_err++;
        end
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("[TB] FAIL %s unexpected byte: got valid with data 0x%02h, required no output", tag, bus.mpeg_data);
        end else begin
          e = exp_q.pop_front();
          check_val({tag, " byte/sync"}, {23'd0, bus.mpeg_sync, bus.mpeg_data}, {23'd0, e.sync, e.data});
        end
        if (n_seen == poke_at) begin
          bus.wen = 1'b1; bus.waddr = 11'd130; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        end
        if (n_seen == stop_at) begin
          if (action == 1) begin
            bus.wen = 1'b1; bus.waddr = 11'd0; bus.wdata = 32'h2; bus.wstrb = 4'hF;
          end else begin
            rst = 1'b1;
          end
          @(negedge clk);
          bus.wen = 1'b0;
          rst     = 1'b0;
          check_val({tag, " valid after stop"}, {31'd0, bus.mpeg_valid}, 32'd0);
          check_val({tag, " sync after stop"}, {31'd0, bus.mpeg_sync}, 32'd0);
          if (action == 2) begin
            check_val({tag, " data after reset"}, {24'd0, bus.mpeg_data}, 32'd0);
            check_val({tag, " rdata after reset"}, bus.rdata, 32'd0);
          end
          fin = 1;
        end
      end
      if (!fin && exp_q.size() == 0 && stop_at == 0 && cyc > last_cyc + gap + 6) fin = 1;
      if (!fin && cyc >= limit) begin
        n_checks++; n_errors++;
        $display("[TB] FAIL %s timeout: %0d bytes seen, %0d still expected", tag, n_seen, exp_q.size());
        fin = 1;
      end
    end
    check_val({tag, " byte spacing errors"}, spacing_err, 0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.ren = 1'b0; bus.raddr = '0;
    for (int i = 0; i < 188; i++) pkt[i] = 8'(i);
    pkt[0] = 8'h47; pkt[1] = 8'h15; pkt[2] = 8'h7F; pkt[3] = 8'h10;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset valid", {31'd0, bus.mpeg_valid}, 32'd0);
    check_val("reset sync", {31'd0, bus.mpeg_sync}, 32'd0);
    check_val("reset data", {24'd0, bus.mpeg_data}, 32'd0);
    check_val("reset rdata", bus.rdata, 32'd0);
    rst = 1'b0;

    vecs.push_back(mkv(1'b0, 11'd1,   32'h0,        4'h0, 32'h3,        "gap reset"));
    vecs.push_back(mkv(1'b0, 11'd2,   32'h0,        4'h0, 32'h0,        "pkt_count reset"));
    vecs.push_back(mkv(1'b0, 11'd3,   32'h0,        4'h0, 32'h0,        "status reset"));
    vecs.push_back(mkv(1'b0, 11'd0,   32'h0,        4'h0, 32'h0,        "ctrl write-only"));
    vecs.push_back(mkv(1'b0, 11'd4,   32'h0,        4'h0, 32'h0,        "unmapped 4"));
    vecs.push_back(mkv(1'b0, 11'd175, 32'h0,        4'h0, 32'h0,        "unmapped 175"));
    vecs.push_back(mkv(1'b1, 11'd1,   32'h5,        4'hF, 32'h5,        "gap write"));
    vecs.push_back(mkv(1'b1, 11'd1,   32'hFFABCD12, 4'hF, 32'h12,       "gap width"));
    vecs.push_back(mkv(1'b1, 11'd2,   32'h12345678, 4'hF, 32'h5678,     "pkt_count width"));
    vecs.push_back(mkv(1'b1, 11'd128, 32'h11223344, 4'hF, 32'h11223344, "buf full word"));
    vecs.push_back(mkv(1'b1, 11'd128, 32'hAABBCCDD, 4'h5, 32'h11BB33DD, "buf byte strobes"));
    vecs.push_back(mkv(1'b1, 11'd174, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, "buf last word"));
    vecs.push_back(mkv(1'b1, 11'd3,   32'hFFFFFFFF, 4'hF, 32'h0,        "status read-only"));
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i]);
    end

    load_packet();

    $display("[TB] single packet, gap 3");
    reg_write(11'd1, 32'd3, 4'hF);
    reg_write(11'd2, 32'd1, 4'hF);
    push_packets(1);
    watch(32'h1, 3, 0, 0, 0, 1200, "gap3", n);
    check_val("gap3 valid count", n, 188);
    reg_read(11'd3, rd);
    check_val("gap3 status", rd, 32'h0001_0002);

    $display("[TB] three packets back to back");
    reg_write(11'd1, 32'd0, 4'hF);
    reg_write(11'd2, 32'd3, 4'hF);
    push_packets(3);
    watch(32'h1, 0, 0, 0, 0, 1000, "gap0", n);
    check_val("gap0 valid count", n, 564);
    reg_read(11'd3, rd);
    check_val("gap0 status", rd, 32'h0003_0002);

    $display("[TB] bad sync byte");
    reg_write(11'd128, 32'h0, 4'h1);
    reg_write(11'd1, 32'd3, 4'hF);
    watch(32'h1, 3, 0, 0, 0, 50, "badsync", n);
    check_val("badsync valid count", n, 0);
    reg_read(11'd3, rd);
    check_val("badsync status", rd, 32'h0000_0004);
    reg_write(11'd128, 32'h47, 4'h1);

    $display("[TB] continuous run with abort");
    reg_write(11'd1, 32'd0, 4'hF);
    reg_write(11'd2, 32'd0, 4'hF);
    push_packets(3);
    watch(32'h1, 0, 50, 500, 1, 800, "abort", n);
    check_val("abort valid count", n, 500);
    reg_read(11'd3, rd);
    check_val("abort status", rd, 32'h0002_0008);
    reg_read(11'd130, rd);
    check_val("abort buffer untouched", rd, word_of(2));

    $display("[TB] reset mid-packet");
    reg_write(11'd1, 32'd2, 4'hF);
    reg_write(11'd2, 32'd0, 4'hF);
    push_packets(1);
    watch(32'h1, 2, 0, 100, 2, 800, "reset", n);
    reg_read(11'd1, rd);
    check_val("reset gap default", rd, 32'h3);
    reg_read(11'd2, rd);
    check_val("reset pkt_count", rd, 32'h0);
    reg_read(11'd3, rd);
    check_val("reset status", rd, 32'h0);
    for (int w = 0; w < 47; w++) begin
      reg_read(11'(128 + w), rd);
      check_val("reset buffer kept", rd, word_of(w));
    end

    $display("[TB] start and abort together");
    watch(32'h3, 3, 0, 0, 0, 50, "startabort", n);
    check_val("startabort valid count", n, 0);
    reg_read(11'd3, rd);
    check_val("startabort status", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
